// File: rtl/hist_readout_pkg.sv
// Shared types and constants for the histogram readout chain.
// FSM encoding, default sync header bytes and the frame-size formula.
package hist_readout_pkg;

    localparam int         LENGTH_ADDR_DEFAULT = 10;
    localparam logic [7:0] SYNC0_DEFAULT       = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT       = 8'h5A;

    // Header (2) + two bytes per bin + checksum (2).
    function automatic int frame_bytes(input int length_addr);
        return 4 + 2 * (2 ** length_addr);
    endfunction

    localparam int FRAME_BYTES = frame_bytes(LENGTH_ADDR_DEFAULT);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC_A,
        ST_SYNC_B,
        ST_FETCH,
        ST_WAIT_RAM,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_CKS_HI,
        ST_CKS_LO,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector that produces a single-cycle pulse.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign pulse = sync_reg & ~prev_reg;

endmodule

// File: rtl/hist_frame_reader.sv
// Sweeps the histogram RAM and streams it to a byte UART as
// SYNC0, SYNC1, bins (high byte first), 16-bit checksum.
module hist_frame_reader
    import hist_readout_pkg::*;
#(
    parameter int         WIDTH_DATA  = 16,
    parameter int         LENGTH_ADDR = LENGTH_ADDR_DEFAULT,
    parameter logic [7:0] SYNC0       = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1       = SYNC1_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH_DATA-1:0]  ram_data,
    output logic [LENGTH_ADDR-1:0] ram_addr,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   hist_freeze,
    output logic                   done
);

    localparam logic [LENGTH_ADDR-1:0] LAST_ADDR = '1;

    state_t                  state_reg, state_next;
    logic [LENGTH_ADDR-1:0]  addr_reg, addr_next;
    logic [WIDTH_DATA-1:0]   word_reg, word_next;
    logic [WIDTH_DATA-1:0]   cks_reg, cks_next;
    logic                    start_pulse;

    sync_edge u_start_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (start),
        .pulse (start_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            word_reg  <= '0;
            cks_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            word_reg  <= word_next;
            cks_reg   <= cks_next;
        end
    end

    // Outputs are decoded from registered state only, so an async reset
    // clears them immediately. Byte states advance on byte_ready because
    // byte_valid is always high in those states.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        word_next  = word_reg;
        cks_next   = cks_reg;
        ram_addr   = addr_reg;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_pulse) begin
                    cks_next   = '0;
                    state_next = ST_SYNC_A;
                end
            end
            ST_SYNC_A: begin
                byte_data  = SYNC0;
                byte_valid = 1'b1;
                if (byte_ready) state_next = ST_SYNC_B;
            end
            ST_SYNC_B: begin
                byte_data  = SYNC1;
                byte_valid = 1'b1;
                if (byte_ready) begin
                    addr_next  = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_WAIT_RAM;
            ST_WAIT_RAM: begin
                word_next  = ram_data;
                cks_next   = cks_reg + ram_data;
                state_next = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                byte_data  = word_reg[15:8];
                byte_valid = 1'b1;
                if (byte_ready) state_next = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                byte_data  = word_reg[7:0];
                byte_valid = 1'b1;
                if (byte_ready) begin
                    if (addr_reg == LAST_ADDR) begin
                        state_next = ST_CKS_HI;
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_CKS_HI: begin
                byte_data  = cks_reg[15:8];
                byte_valid = 1'b1;
                if (byte_ready) state_next = ST_CKS_LO;
            end
            ST_CKS_LO: begin
                byte_data  = cks_reg[7:0];
                byte_valid = 1'b1;
                if (byte_ready) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                addr_next  = '0;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign hist_freeze = busy;

endmodule

// File: tb/tb_hist_frame_reader.sv
// Scoreboard bench for hist_frame_reader: expected frame bytes are queued
// when a start is issued and matched against bytes the DUT hands off.
`timescale 1ns/1ps
module tb_hist_frame_reader;

    localparam int LA       = 10;
    localparam int NBINS    = 1 << LA;
    localparam int NBYTES   = 4 + 2 * NBINS;
    localparam int BUSY_MIN = 2 + 4 * NBINS + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          byte_ready = 1'b1;
    logic [15:0]   ram_data;
    logic [LA-1:0] ram_addr;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          busy;
    logic          hist_freeze;
    logic          done;

    logic [15:0] mem [0:NBINS-1];
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int busy_cycles = 0;
    int freeze_bad = 0;

    hist_frame_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ram_data    (ram_data),
        .ram_addr    (ram_addr),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .busy        (busy),
        .hist_freeze (hist_freeze),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_data <= mem[ram_addr];

    // Inputs change just after posedge, so a negedge sample sees exactly
    // what the next posedge will act on.
    always @(negedge clk) begin
        if (byte_valid && byte_ready) obs_q.push_back(byte_data);
        if (done) done_count++;
        if (busy) busy_cycles++;
        if (hist_freeze !== busy) freeze_bad++;
    end

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        done_count  = 0;
        busy_cycles = 0;
        freeze_bad  = 0;
    endtask

    task automatic push_frame();
        logic [15:0] sum;
        sum = 16'h0000;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < NBINS; i++) begin
            exp_q.push_back(mem[i][15:8]);
            exp_q.push_back(mem[i][7:0]);
            sum = sum + mem[i];
        end
        exp_q.push_back(sum[15:8]);
        exp_q.push_back(sum[7:0]);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            if (done_count > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d, expected 0", ram_addr); end
        checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", byte_data); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", byte_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (hist_freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b, expected 0", hist_freeze); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("reset: outputs idle after reset release");
    endtask

    task automatic test_all_zero();
        bit ok;
        int idx;
        logic [7:0] e, o;
        for (int i = 0; i < NBINS; i++) mem[i] = 16'h0000;
        clear_sb();
        start = 1'b1;
        push_frame();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_early: busy %b after 2 edges, expected 0", busy); end
        @(posedge clk); #1;
        checks++; if ({busy, hist_freeze, byte_valid} !== 3'b111) begin errors++; $display("FAIL start_latency: busy/freeze/valid %b, expected 111", {busy, hist_freeze, byte_valid}); end
        checks++; if (byte_data !== 8'hA5) begin errors++; $display("FAIL start_sync0: got %02h, expected a5", byte_data); end
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_timeout: done=%0d, expected 1", done_count); end
        checks++; if (obs_q.size() !== NBYTES) begin errors++; $display("FAIL zero_count: got %0d, expected %0d", obs_q.size(), NBYTES); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL zero_byte[%0d]: got %02h, expected %02h", idx, o, e); end
            idx++;
        end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL zero_done: got %0d pulses, expected 1", done_count); end
        checks++; if (busy_cycles !== BUSY_MIN) begin errors++; $display("FAIL zero_busy: got %0d cycles, expected %0d", busy_cycles, BUSY_MIN); end
        checks++; if (freeze_bad !== 0) begin errors++; $display("FAIL zero_freeze: %0d cycles freeze!=busy, expected 0", freeze_bad); end
        $display("frame all_zero: %0d bytes compared", idx);
    endtask

    task automatic test_ramp();
        bit ok;
        int idx, n;
        logic [7:0] e, o;
        logic [15:0] cks;
        for (int i = 0; i < NBINS; i++) mem[i] = 16'(i);
        clear_sb();
        start = 1'b1;
        push_frame();
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ramp_timeout: done=%0d, expected 1", done_count); end
        n = obs_q.size();
        cks = (n >= 2) ? {obs_q[n-2], obs_q[n-1]} : 16'hxxxx;
        checks++; if (cks !== 16'hFE00) begin errors++; $display("FAIL ramp_cks: got %04h, expected fe00", cks); end
        checks++; if (n !== NBYTES) begin errors++; $display("FAIL ramp_count: got %0d, expected %0d", n, NBYTES); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL ramp_byte[%0d]: got %02h, expected %02h", idx, o, e); end
            idx++;
        end
        $display("frame ramp: %0d bytes, checksum %04h", idx, cks);
    endtask

    task automatic test_ones();
        bit ok;
        int idx, n;
        logic [7:0] e, o;
        logic [15:0] cks;
        for (int i = 0; i < NBINS; i++) mem[i] = 16'hFFFF;
        clear_sb();
        start = 1'b1;
        push_frame();
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ones_timeout: done=%0d, expected 1", done_count); end
        n = obs_q.size();
        cks = (n >= 2) ? {obs_q[n-2], obs_q[n-1]} : 16'hxxxx;
        checks++; if (cks !== 16'hFC00) begin errors++; $display("FAIL ones_cks: got %04h, expected fc00", cks); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL ones_byte[%0d]: got %02h, expected %02h", idx, o, e); end
            idx++;
        end
        $display("frame all_ones: %0d bytes, checksum %04h", idx, cks);
    endtask

    task automatic test_backpressure();
        bit ok, found;
        int idx;
        logic [7:0] e, o;
        for (int i = 0; i < NBINS; i++) mem[i] = 16'($urandom);
        clear_sb();
        start = 1'b1;
        push_frame();
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (byte_valid && obs_q.size() == 2) begin
                found = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL bp_reach: 3rd byte not valid, seen %0d bytes", obs_q.size()); end
        byte_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (byte_valid !== 1'b1 || byte_data !== mem[0][15:8]) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid %b data %02h, expected 1 %02h", k, byte_valid, byte_data, mem[0][15:8]);
            end
        end
        @(posedge clk); #1;
        byte_ready = 1'b1;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: done=%0d, expected 1", done_count); end
        checks++; if (obs_q.size() !== NBYTES) begin errors++; $display("FAIL bp_count: got %0d, expected %0d", obs_q.size(), NBYTES); end
        checks++; if (busy_cycles !== BUSY_MIN + 5) begin errors++; $display("FAIL bp_busy: got %0d cycles, expected %0d", busy_cycles, BUSY_MIN + 5); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL bp_byte[%0d]: got %02h, expected %02h", idx, o, e); end
            idx++;
        end
        $display("frame backpressure: %0d bytes with 5-cycle stall", idx);
    endtask

    task automatic test_restart_ignored();
        bit ok;
        int idx;
        logic [7:0] e, o;
        for (int i = 0; i < NBINS; i++) mem[i] = 16'($urandom);
        clear_sb();
        start = 1'b1;
        push_frame();
        repeat (400) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL restart_timeout: done=%0d, expected 1", done_count); end
        repeat (60) @(posedge clk);
        #1;
        checks++; if (done_count !== 1) begin errors++; $display("FAIL restart_done: got %0d pulses, expected 1", done_count); end
        checks++; if (busy_cycles !== BUSY_MIN) begin errors++; $display("FAIL restart_busy: got %0d cycles, expected %0d", busy_cycles, BUSY_MIN); end
        checks++; if (obs_q.size() !== NBYTES) begin errors++; $display("FAIL restart_count: got %0d, expected %0d", obs_q.size(), NBYTES); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL restart_byte[%0d]: got %02h, expected %02h", idx, o, e); end
            idx++;
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("frame restart_ignored: %0d bytes, single frame", idx);
    endtask

    task automatic test_reset_midframe();
        bit ok, found;
        int idx;
        logic [7:0] e, o;
        for (int i = 0; i < NBINS; i++) mem[i] = 16'($urandom);
        clear_sb();
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            if (ram_addr == LA'(500)) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_reach: addr %0d, expected 500", ram_addr); end
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL mid_addr: got %0d, expected 0", ram_addr); end
        checks++; if ({byte_valid, busy, hist_freeze, done} !== 4'b0000) begin errors++; $display("FAIL mid_flags: valid/busy/freeze/done %b, expected 0000", {byte_valid, busy, hist_freeze, done}); end
        checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %02h, expected 00", byte_data); end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NBINS; i++) mem[i] = 16'($urandom);
        repeat (2) @(posedge clk);
        #1;
        clear_sb();
        start = 1'b1;
        push_frame();
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_timeout: done=%0d, expected 1", done_count); end
        checks++; if (obs_q.size() !== NBYTES) begin errors++; $display("FAIL mid_count: got %0d, expected %0d", obs_q.size(), NBYTES); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL mid_byte[%0d]: got %02h, expected %02h", idx, o, e); end
            idx++;
        end
        $display("frame after_midframe_reset: %0d bytes", idx);
    endtask

    initial begin
        for (int i = 0; i < NBINS; i++) mem[i] = 16'h0000;
        test_reset();
        test_all_zero();
        test_ramp();
        test_ones();
        test_backpressure();
        test_restart_ignored();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hist_frame_reader.md
Name: hist_frame_reader

Overview:
- Downstream readout stage of the ADC code-density chain. It sits between the histogram RAM read port (port B) and a byte-oriented UART transmitter.
- On a start request it sweeps every histogram bin, splits each 16-bit count into bytes, and wraps them in a frame: sync header, bin payload, 16-bit checksum.
- It asserts a freeze flag while reading so the histogrammer stops updating during the dump.

Parameters:
- WIDTH_DATA, 16, histogram bin width; must be 16.
- LENGTH_ADDR, 10, RAM address width; bin count is 2^LENGTH_ADDR.
- SYNC0, 8'hA5, first header byte.
- SYNC1, 8'h5A, second header byte.

Ports:
- clk  in  1  system clock (100 MHz PLL clock).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  asynchronous request (push-button level); a rising edge starts a frame.
- ram_data  in  WIDTH_DATA  RAM port-B read data; synchronous read, 1-cycle latency.
- ram_addr  out  LENGTH_ADDR  RAM port-B address.
- byte_data  out  8  byte to UART.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  UART accepts the byte.
- busy  out  1  frame in progress.
- hist_freeze  out  1  histogrammer must hold RAM writes.
- done  out  1  one-cycle pulse after the last checksum byte is accepted.

Behaviour:
- Reset (rst=0, async): state IDLE. ram_addr=0, byte_data=0, byte_valid=0, busy=0, hist_freeze=0, done=0, checksum=0, synchronizer flops=0.
- Start path: start passes through a 2-FF synchronizer, then a rising-edge detect.
  - In IDLE, a detected edge moves the FSM to SYNC_A.
  - busy, hist_freeze and byte_valid (with byte_data=SYNC0) are all high on the 3rd clk edge after start is first sampled high.
  - Edges seen outside IDLE are ignored and not queued.
- Handshake:
  - A transfer occurs on a clk edge where byte_valid && byte_ready.
  - While valid && !ready, byte_data holds stable and byte_valid stays high.
  - byte_valid never deasserts without a transfer, except on reset.
- FSM states, in order:
  - IDLE.
  - SYNC_A: present SYNC0.
  - SYNC_B: present SYNC1.
  - FETCH: drive ram_addr, valid=0.
  - WAIT_RAM: latch ram_data into word_reg and add it to checksum.
  - SEND_HI: present word_reg[15:8].
  - SEND_LO: present word_reg[7:0].
  - CKS_HI: present checksum[15:8].
  - CKS_LO: present checksum[7:0].
  - DONE: pulse done, clear busy and freeze, return to IDLE next cycle.
- Transitions:
  - SYNC_A advances to SYNC_B on a transfer.
  - SYNC_B advances to FETCH (ram_addr=0) on a transfer.
  - SEND_LO on a transfer:
    - if ram_addr == 2^LENGTH_ADDR-1, go to CKS_HI;
    - else increment ram_addr and go to FETCH.
  - CKS_LO advances to DONE on a transfer.
- Frame content:
  - 2 + 2*2^LENGTH_ADDR + 2 bytes, i.e. 2052 at defaults.
  - Bins are sent in ascending address order, high byte first.
- Checksum: 16-bit sum of all bin words, modulo 2^16, carries discarded. Cleared on entry to SYNC_A.
- Address range:
  - ram_addr never wraps past the last bin.
  - In IDLE, ram_addr returns to 0 on the DONE→IDLE transition.
- hist_freeze is high from SYNC_A through DONE inclusive, and equals busy.
- Throughput: each bin costs 2 cycles overhead plus two handshakes. With byte_ready held high, one bin takes 4 cycles.
- Reset mid-frame: immediately aborts to IDLE with all outputs cleared. No partial checksum is emitted.

Decomposition:
- Shared package hist_readout_pkg:
  - state enum/localparams;
  - SYNC0/SYNC1 defaults;
  - FRAME_BYTES = 4 + 2*2^LENGTH_ADDR.
- One sub-module, sync_edge: 2-FF synchronizer plus rising-edge pulse, async active-low reset. It is reused for the stop input elsewhere.

Test Plan:
- RAM all 0, byte_ready=1, pulse start → A5, 5A, 2048×00, 00, 00; done pulses once; busy high exactly frame duration.
- RAM bin[i]=i → payload 00 00, 00 01, …, 03 FF; checksum 0xFE00 (sum 0..1023 mod 2^16).
- RAM all 0xFFFF → checksum 0xFC00; confirms carries are discarded.
- byte_ready low 5 cycles while 3rd byte (bin0 hi) is valid → byte_data and byte_valid stable for all 5 cycles; no byte skipped or duplicated; total byte count 2052.
- Second start edge mid-frame → ignored; exactly one frame emitted; start held high after done → no new frame without a new rising edge.
- rst low during bin 500 → all outputs 0 asynchronously; after release and a new start, a full correct frame with fresh checksum.
